lcd_alarm_flash_overlay: RTL and testbench

Post-processing stage placed directly downstream of the LCD timing/compositor stage, between its RGB565 and sync outputs and the LCD pins. When an alarm fires, it flashes a coloured border around the active area for a fixed number of on/off phases. Flash phases change only on frame boundaries, so no frame tears. Otherwise it is a transparent 1-cycle register stage for data and sync.

---
 rtl/lcd_alarm_flash_overlay_pkg.sv | 26 ++
 rtl/lcd_pos_tracker.sv | 48 ++++
 rtl/lcd_alarm_flash_overlay.sv | 159 +++++++++++++++
 tb/tb_lcd_alarm_flash_overlay.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/lcd_alarm_flash_overlay_pkg.sv
// rtl/lcd_alarm_flash_overlay_pkg.sv - shared display types and constants for the alarm flash overlay
package lcd_alarm_flash_overlay_pkg;

  // RGB565 field widths
  localparam int R_W   = 5;
  localparam int G_W   = 6;
  localparam int B_W   = 5;
  localparam int RGB_W = R_W + G_W + B_W;

  // Position counter widths
  localparam int POS_X_W = 11;
  localparam int POS_Y_W = 10;

  // Colour constants {R5,G6,B5}
  localparam logic [RGB_W-1:0] RGB_WHITE      = 16'hFFFF;
  localparam logic [RGB_W-1:0] RGB_BORDER_RED = 16'hF800;

  // Flash sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_ON    = 2'd2,
    ST_OFF   = 2'd3
  } flash_state_e;

endpackage

// File: rtl/lcd_pos_tracker.sv
// rtl/lcd_pos_tracker.sv - DE/vsync edge detection, pixel x/y counters and frame tick
module lcd_pos_tracker
  import lcd_alarm_flash_overlay_pkg::*;
(
  input  logic               PixelClk,
  input  logic               nRST,
  input  logic               in_de,
  input  logic               in_vsync,
  output logic [POS_X_W-1:0] x,
  output logic [POS_Y_W-1:0] y,
  output logic               frame_tick
);

  localparam logic [POS_X_W-1:0] X_MAX = '1;
  localparam logic [POS_Y_W-1:0] Y_MAX = '1;

  logic de_q;
  logic vsync_q;
  logic de_fall;

  // x and y hold the pre-increment position of the pixel currently on the inputs
  assign de_fall    = de_q & ~in_de;
  assign frame_tick = vsync_q & ~in_vsync;

  // Edge history plus saturating x (per DE cycle) and y (per line end) counters
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      de_q    <= 1'b0;
      vsync_q <= 1'b0;
      x       <= '0;
      y       <= '0;
    end else begin
      de_q    <= in_de;
      vsync_q <= in_vsync;
      if (in_de) begin
        if (x != X_MAX) x <= x + 1'b1;
      end else begin
        x <= '0;
      end
      if (frame_tick) begin
        y <= '0;
      end else if (de_fall && (y != Y_MAX)) begin
        y <= y + 1'b1;
      end
    end
  end

endmodule

// File: rtl/lcd_alarm_flash_overlay.sv
// rtl/lcd_alarm_flash_overlay.sv - 1-cycle LCD output stage that flashes a border on alarm
module lcd_alarm_flash_overlay
  import lcd_alarm_flash_overlay_pkg::*;
#(
  parameter int               ACTIVE_W            = 800,
  parameter int               ACTIVE_H            = 480,
  parameter int               BORDER_W            = 8,
  parameter int               FLASH_PERIOD_FRAMES = 30,
  parameter int               FLASH_COUNT         = 10,
  parameter logic [RGB_W-1:0] BORDER_RGB          = RGB_BORDER_RED
) (
  input  logic           PixelClk,
  input  logic           nRST,
  input  logic           in_de,
  input  logic           in_hsync,
  input  logic           in_vsync,
  input  logic [R_W-1:0] in_r,
  input  logic [G_W-1:0] in_g,
  input  logic [B_W-1:0] in_b,
  input  logic           alarm_trigger,
  input  logic           alarm_ack,
  output logic           out_de,
  output logic           out_hsync,
  output logic           out_vsync,
  output logic [R_W-1:0] out_r,
  output logic [G_W-1:0] out_g,
  output logic [B_W-1:0] out_b,
  output logic           flashing
);

  localparam int FC_W = $clog2(FLASH_PERIOD_FRAMES + 1);
  localparam int CL_W = $clog2(FLASH_COUNT + 1);

  localparam logic [FC_W-1:0]    FC_LAST = FC_W'(FLASH_PERIOD_FRAMES - 1);
  localparam logic [CL_W-1:0]    CL_LOAD = CL_W'(FLASH_COUNT);
  localparam logic [POS_X_W-1:0] X_LO    = POS_X_W'(BORDER_W);
  localparam logic [POS_X_W-1:0] X_HI    = POS_X_W'(ACTIVE_W - BORDER_W);
  localparam logic [POS_Y_W-1:0] Y_LO    = POS_Y_W'(BORDER_W);
  localparam logic [POS_Y_W-1:0] Y_HI    = POS_Y_W'(ACTIVE_H - BORDER_W);

  logic [POS_X_W-1:0] x;
  logic [POS_Y_W-1:0] y;
  logic               frame_tick;
  logic               border_pix;
  logic [RGB_W-1:0]   rgb_q;

  flash_state_e    state, state_nxt;
  logic [FC_W-1:0] frame_cnt, frame_cnt_nxt;
  logic [CL_W-1:0] cycles_left, cycles_left_nxt;
  logic            overlay_vis, overlay_vis_d;
  logic            flashing_d;

  lcd_pos_tracker u_pos (
    .PixelClk   (PixelClk),
    .nRST       (nRST),
    .in_de      (in_de),
    .in_vsync   (in_vsync),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick)
  );

  // Border membership; x beyond the active width (incl. saturated x) lands in the right band
  assign border_pix = in_de && ((x < X_LO) || (x >= X_HI) || (y < Y_LO) || (y >= Y_HI));

  // Pixel/sync register stage: sync and DE untouched, colour replaced only on visible border
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      out_de    <= 1'b0;
      out_hsync <= 1'b1;
      out_vsync <= 1'b1;
      rgb_q     <= RGB_WHITE;
    end else begin
      out_de    <= in_de;
      out_hsync <= in_hsync;
      out_vsync <= in_vsync;
      rgb_q     <= (border_pix && overlay_vis) ? BORDER_RGB : {in_r, in_g, in_b};
    end
  end

  assign out_r = rgb_q[RGB_W-1 -: R_W];
  assign out_g = rgb_q[B_W +: G_W];
  assign out_b = rgb_q[B_W-1:0];

  // Sequencer state and counter registers
  always_ff @(posedge PixelClk or negedge nRST) begin
    if (!nRST) begin
      state       <= ST_IDLE;
      frame_cnt   <= '0;
      cycles_left <= '0;
      overlay_vis <= 1'b0;
      flashing    <= 1'b0;
    end else begin
      state       <= state_nxt;
      frame_cnt   <= frame_cnt_nxt;
      cycles_left <= cycles_left_nxt;
      overlay_vis <= overlay_vis_d;
      flashing    <= flashing_d;
    end
  end

  // Next-state: ack dominates; phases advance only on frame ticks; trigger re-arms the count
  always_comb begin
    state_nxt       = state;
    frame_cnt_nxt   = frame_cnt;
    cycles_left_nxt = cycles_left;
    if (alarm_ack) begin
      state_nxt       = ST_IDLE;
      frame_cnt_nxt   = '0;
      cycles_left_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (alarm_trigger) begin
            state_nxt       = ST_ARMED;
            cycles_left_nxt = CL_LOAD;
          end
        end
        ST_ARMED: begin
          if (frame_tick) begin
            state_nxt     = ST_ON;
            frame_cnt_nxt = '0;
          end
        end
        ST_ON: begin
          if (frame_tick) begin
            if (frame_cnt == FC_LAST) begin
              state_nxt     = ST_OFF;
              frame_cnt_nxt = '0;
              if (cycles_left != '0) cycles_left_nxt = cycles_left - 1'b1;
            end else begin
              frame_cnt_nxt = frame_cnt + 1'b1;
            end
          end
        end
        ST_OFF: begin
          if (frame_tick) begin
            if (frame_cnt == FC_LAST) begin
              frame_cnt_nxt = '0;
              state_nxt     = (cycles_left != '0) ? ST_ON : ST_IDLE;
            end else begin
              frame_cnt_nxt = frame_cnt + 1'b1;
            end
          end
        end
        default: state_nxt = ST_IDLE;
      endcase
      if (alarm_trigger && (state != ST_IDLE)) cycles_left_nxt = CL_LOAD;
    end
  end

  // Outputs: visibility latched only at frame boundaries so a frame never tears
  always_comb begin
    flashing_d    = (state_nxt != ST_IDLE);
    overlay_vis_d = overlay_vis;
    if (frame_tick) overlay_vis_d = (state_nxt == ST_ON);
  end

endmodule

// File: tb/tb_lcd_alarm_flash_overlay.sv
// tb/tb_lcd_alarm_flash_overlay.sv - scoreboard bench for the alarm flash overlay
module tb_lcd_alarm_flash_overlay;

  logic       PixelClk = 1'b0;
  logic       nRST;
  logic       in_de, in_hsync, in_vsync;
  logic [4:0] in_r, in_b;
  logic [5:0] in_g;
  logic       alarm_trigger, alarm_ack;
  logic       out_de, out_hsync, out_vsync;
  logic [4:0] out_r, out_b;
  logic [5:0] out_g;
  logic       flashing;

  typedef struct packed {
    logic [31:0] id;
    logic [19:0] v;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned seq   = 0;

  localparam logic [19:0] RESET_OUT = {1'b0, 1'b1, 1'b1, 16'hFFFF, 1'b0};

  lcd_alarm_flash_overlay #(
    .ACTIVE_W            (16),
    .ACTIVE_H            (8),
    .BORDER_W            (2),
    .FLASH_PERIOD_FRAMES (2),
    .FLASH_COUNT         (2),
    .BORDER_RGB          (16'hF800)
  ) dut (
    .PixelClk      (PixelClk),
    .nRST          (nRST),
    .in_de         (in_de),
    .in_hsync      (in_hsync),
    .in_vsync      (in_vsync),
    .in_r          (in_r),
    .in_g          (in_g),
    .in_b          (in_b),
    .alarm_trigger (alarm_trigger),
    .alarm_ack     (alarm_ack),
    .out_de        (out_de),
    .out_hsync     (out_hsync),
    .out_vsync     (out_vsync),
    .out_r         (out_r),
    .out_g         (out_g),
    .out_b         (out_b),
    .flashing      (flashing)
  );

  always #5 PixelClk = ~PixelClk;

  function automatic logic [19:0] outs();
    return {out_de, out_hsync, out_vsync, out_r, out_g, out_b, flashing};
  endfunction

  task automatic check(input string name, input logic [19:0] got, input logic [19:0] want);
    n_cmp++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // One input cycle; expected output {de,hs,vs,rgb,flashing} is queued for the monitor
  task automatic drive(input logic de, input logic hs, input logic vs, input logic tr,
                       input logic ak, input logic bord, input logic fl);
    logic [15:0] rgb;
    rgb = 16'($urandom);
    @(negedge PixelClk);
    in_de = de; in_hsync = hs; in_vsync = vs;
    {in_r, in_g, in_b} = rgb;
    alarm_trigger = tr; alarm_ack = ak;
    sb.push_back('{id: seq, v: {de, hs, vs, (bord ? 16'hF800 : rgb), fl}});
    seq++;
  endtask

  // Synthetic frame: 20-cycle lines, 12 lines; DE at p 2..17 of lines 0..7, vsync high on line 11
  task automatic run_frame(input int c0, input int c1, input logic vis, input int ev,
                           input logic tr, input logic ak, input logic fl0, input logic fl1);
    for (int c = c0; c < c1; c++) begin
      int   l;
      int   p;
      int   x;
      logic de;
      logic bord;
      l    = c / 20;
      p    = c % 20;
      x    = p - 2;
      de   = (l < 8) && (p >= 2) && (p < 18);
      bord = de && vis && ((x < 2) || (x >= 14) || (l < 2) || (l >= 6));
      drive(de, !(p >= 18), (l == 11), (c == ev) && tr, (c == ev) && ak, bord,
            ((ev >= 0) && (c >= ev)) ? fl1 : fl0);
    end
  endtask

  task automatic frame(input logic vis, input int ev, input logic tr, input logic ak,
                       input logic fl0, input logic fl1);
    run_frame(0, 240, vis, ev, tr, ak, fl0, fl1);
  endtask

  // Monitor: every registered output is compared against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge PixelClk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check($sformatf("out#%0d", e.id), outs(), e.v);
      end
    end
  end

  initial begin
    #1000000;
    n_err++;
    $display("FAIL watchdog got=timeout want=finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    nRST = 1'b0;
    in_de = 1'b0; in_hsync = 1'b1; in_vsync = 1'b0;
    in_r = '0; in_g = '0; in_b = '0;
    alarm_trigger = 1'b0; alarm_ack = 1'b0;
    #12;
    check("reset_init", outs(), RESET_OUT);
    @(negedge PixelClk);
    nRST = 1'b1;

    // Passthrough with random data and syncs, no alarm
    repeat (100) drive(1'($urandom), 1'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);

    // Full alarm: ARMED, ON x2, OFF x2, ON x2, trailing OFF x2, then IDLE
    frame(1'b0, 50, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) frame(1'b1, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) frame(1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) frame(1'b1, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) frame(1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Ack mid-frame in ON: flashing drops at once, border holds to frame end
    frame(1'b0, 50, 1'b1, 1'b0, 1'b0, 1'b1);
    frame(1'b1, 100, 1'b0, 1'b1, 1'b1, 1'b0);
    frame(1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Trigger and ack together in ON behave as ack
    frame(1'b0, 50, 1'b1, 1'b0, 1'b0, 1'b1);
    frame(1'b1, 100, 1'b1, 1'b1, 1'b1, 1'b0);
    frame(1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Trigger during the final OFF phase reloads the count: two more ON phases follow
    frame(1'b0, 50, 1'b1, 1'b0, 1'b0, 1'b1);
    repeat (2) frame(1'b1, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) frame(1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) frame(1'b1, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(1'b0, 50, 1'b1, 1'b0, 1'b1, 1'b1);
    frame(1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) frame(1'b1, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) frame(1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) frame(1'b1, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) frame(1'b0, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    frame(1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Saturation: inside an ON frame, y=4 line with DE held for 2100 cycles
    frame(1'b0, 50, 1'b1, 1'b0, 1'b0, 1'b1);
    run_frame(0, 80, 1'b1, -1, 1'b0, 1'b0, 1'b1, 1'b1);
    repeat (2) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 2100; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, (k < 2) || (k >= 14), 1'b1);
    repeat (20) drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (20) drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(1'b1, 100, 1'b0, 1'b1, 1'b1, 1'b0);
    frame(1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-line, then resume and prove y resynchronises
    run_frame(0, 66, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);
    @(posedge PixelClk);
    #3;
    nRST = 1'b0;
    #1;
    check("reset_async", outs(), RESET_OUT);
    repeat (2) @(posedge PixelClk);
    #1;
    check("reset_hold", outs(), RESET_OUT);
    @(negedge PixelClk);
    nRST = 1'b1;
    run_frame(66, 240, 1'b0, 150, 1'b1, 1'b0, 1'b0, 1'b1);
    frame(1'b1, 200, 1'b0, 1'b1, 1'b1, 1'b0);
    frame(1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b0);

    repeat (4) @(posedge PixelClk);
    #2;
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain got=%0d want=0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
